// File: rtl/sonata_clkgen.sv
// sonata_clkgen: reset and clock-enable sequencer for the Sonata FPGA top.
// Emulates PLL lock after board reset, stretches the system reset, then
// releases an active-low system reset plus a divided clock-enable pulse.
// Optional LED heartbeat is built only when SONATA_CLKGEN_HEARTBEAT_EN is
// defined; otherwise heartbeat_o is tied to 0.
// No valid/ready handshakes: every output is a level or a one-cycle pulse.
module sonata_clkgen #(
   parameter int unsigned LockCycles       = 16,
   parameter int unsigned RstStretchCycles = 8,
   parameter int unsigned CeDiv            = 2,
   parameter int unsigned HbHalfPeriod     = 5000000
) (
   input  logic IO_CLK,
   input  logic IO_RST,
   input  logic ext_rst_req_i,
   output logic locked_o,
   output logic rst_sys_n_o,
   output logic clk_en_o,
   output logic heartbeat_o
);

   localparam int unsigned lock_w = $clog2(LockCycles + 1);
   localparam int unsigned str_w  = $clog2(RstStretchCycles + 1);
   localparam int unsigned ce_w   = $clog2(CeDiv + 1);

   localparam logic [lock_w-1:0] lock_last     = lock_w'(LockCycles - 1);
   localparam logic [str_w-1:0]  str_req_load  = str_w'(RstStretchCycles);
   // The lock edge itself is the first stretch cycle, so that load is one short;
   // this makes rst_sys_n_o rise exactly LockCycles+RstStretchCycles edges in.
   localparam logic [str_w-1:0]  str_lock_load = str_w'(RstStretchCycles - 1);
   localparam logic [ce_w-1:0]   ce_last       = ce_w'(CeDiv - 1);

   logic [lock_w-1:0] lock_cnt;
   logic [str_w-1:0]  str_cnt;
   logic [ce_w-1:0]   ce_cnt;
   logic              req_meta;
   logic              req_s;
   logic              lock_rise;

   assign lock_rise = !locked_o && (lock_cnt == lock_last);

   // Emulated lock: count edges until LockCycles, then hold locked until IO_RST.
   always_ff @(posedge IO_CLK) begin
      if (IO_RST) begin
         lock_cnt <= '0;
         locked_o <= 1'b0;
      end else if (!locked_o) begin
         lock_cnt <= lock_cnt + 1'b1;
         if (lock_cnt == lock_last) begin
            locked_o <= 1'b1;
         end
      end
   end

   // Two-flop synchronizer for the asynchronous reset request.
   always_ff @(posedge IO_CLK) begin
      if (IO_RST) begin
         req_meta <= 1'b0;
         req_s    <= 1'b0;
      end else begin
         req_meta <= ext_rst_req_i;
         req_s    <= req_meta;
      end
   end

   // Stretch counter: a live request reloads it ahead of the lock load and the decrement.
   always_ff @(posedge IO_CLK) begin
      if (IO_RST) begin
         str_cnt <= '0;
      end else if (req_s) begin
         str_cnt <= str_req_load;
      end else if (lock_rise) begin
         str_cnt <= str_lock_load;
      end else if (str_cnt != '0) begin
         str_cnt <= str_cnt - 1'b1;
      end
   end

   // Registered system reset release: locked, stretch expired, no pending request.
   always_ff @(posedge IO_CLK) begin
      if (IO_RST) begin
         rst_sys_n_o <= 1'b0;
      end else begin
         rst_sys_n_o <= locked_o && (str_cnt == '0) && !req_s;
      end
   end

   // Clock-enable divider, parked at 0 while the system is in reset.
   always_ff @(posedge IO_CLK) begin
      if (IO_RST || !rst_sys_n_o) begin
         ce_cnt <= '0;
      end else if (ce_cnt == ce_last) begin
         ce_cnt <= '0;
      end else begin
         ce_cnt <= ce_cnt + 1'b1;
      end
   end

   assign clk_en_o = rst_sys_n_o && (ce_cnt == ce_last);

`ifdef SONATA_CLKGEN_HEARTBEAT_EN
   localparam int unsigned      hb_w      = $clog2(HbHalfPeriod + 1);
   localparam logic [hb_w-1:0]  hb_reload = hb_w'(HbHalfPeriod);

   logic [hb_w-1:0] hb_cnt;

   // Heartbeat: held high in reset, then toggles every HbHalfPeriod+1 edges.
   always_ff @(posedge IO_CLK) begin
      if (IO_RST || !rst_sys_n_o) begin
         hb_cnt      <= hb_reload;
         heartbeat_o <= 1'b1;
      end else if (hb_cnt == '0) begin
         hb_cnt      <= hb_reload;
         heartbeat_o <= !heartbeat_o;
      end else begin
         hb_cnt      <= hb_cnt - 1'b1;
      end
   end
`else
   logic [31:0] unused_hb_half;

   assign unused_hb_half = HbHalfPeriod;
   assign heartbeat_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sonata_clkgen.sv
// tb_sonata_clkgen: self-checking bench for sonata_clkgen.
// Two instances share stimulus: CeDiv=2 (main) and CeDiv=1. Expected output
// vectors {locked, rst_n, clk_en, heartbeat, clk_en(CeDiv=1)} are derived from
// the edge-number formulas, queued before each edge and compared after it.
// Heartbeat expectations follow SONATA_CLKGEN_HEARTBEAT_EN.
module tb_sonata_clkgen;

   localparam int LOCK    = 16;
   localparam int STRETCH = 8;
   localparam int HB_HALF = 9;
`ifdef SONATA_CLKGEN_HEARTBEAT_EN
   localparam bit HB_EN = 1'b1;
`else
   localparam bit HB_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic io_rst;
   logic ext_req;
   logic locked, rst_n, clk_en, hb;
   logic locked1, rst_n1, clk_en1, hb1;

   logic [4:0] exp_q[$];
   int chk_cnt  = 0;
   int pass_cnt = 0;

   sonata_clkgen #(
      .LockCycles(LOCK), .RstStretchCycles(STRETCH), .CeDiv(2), .HbHalfPeriod(HB_HALF)
   ) dut (
      .IO_CLK(clk), .IO_RST(io_rst), .ext_rst_req_i(ext_req),
      .locked_o(locked), .rst_sys_n_o(rst_n), .clk_en_o(clk_en), .heartbeat_o(hb)
   );

   sonata_clkgen #(
      .LockCycles(LOCK), .RstStretchCycles(STRETCH), .CeDiv(1), .HbHalfPeriod(HB_HALF)
   ) dut_div1 (
      .IO_CLK(clk), .IO_RST(io_rst), .ext_rst_req_i(ext_req),
      .locked_o(locked1), .rst_sys_n_o(rst_n1), .clk_en_o(clk_en1), .heartbeat_o(hb1)
   );

   // clock
   always #5 clk = ~clk;

   // hard time limit
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, got=running required=finished");
      $fatal(1);
   end

   // expected vector: k = edges since rst_n last rose (meaningful when rn=1)
   function automatic logic [4:0] exp_vec(input bit lk, input bit rn, input int k);
      bit en;
      bit h;
      en = rn && ((k % 2) == 1);
      if (!HB_EN)  h = 1'b0;
      else if (!rn) h = 1'b1;
      else          h = (((k / (HB_HALF + 1)) % 2) == 0);
      return {lk, rn, en, h, rn};
   endfunction

   function automatic logic [4:0] rst_vec();
      return {1'b0, 1'b0, 1'b0, HB_EN, 1'b0};
   endfunction

   // driver: one edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver: full reset then run to release (rst_n rises at edge LOCK+STRETCH)
   task automatic reset_release();
      io_rst  = 1'b1;
      ext_req = 1'b0;
      repeat (3) tick();
      io_rst = 1'b0;
      repeat (LOCK + STRETCH) tick();
   endtask

   task automatic test_reset();
      logic [4:0] got, exp;
      io_rst  = 1'b1;
      ext_req = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         exp_q.push_back(rst_vec());
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL reset cyc=%0d got=%b exp=%b", i, got, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_power_up();
      logic [4:0] got, exp;
      io_rst = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         exp_q.push_back(exp_vec(e >= LOCK, e >= LOCK + STRETCH, e - (LOCK + STRETCH)));
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL power_up e=%0d got=%b exp=%b", e, got, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_heartbeat();
      logic [4:0] got, exp;
      reset_release();
      for (int k = 1; k <= 45; k++) begin
         exp_q.push_back(exp_vec(1'b1, 1'b1, k));
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL heartbeat k=%0d got=%b exp=%b", k, got, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_ext_req();
      logic [4:0] got, exp;
      int p;
      int rise2;
      bit rn;
      p     = 5;
      rise2 = p + 15;
      reset_release();
      for (int k = 1; k <= rise2 + 25; k++) begin
         ext_req = (k >= 5) && (k <= 4 + p);
         rn = !((k >= 7) && (k <= p + 14));
         exp_q.push_back(exp_vec(1'b1, rn, (k >= rise2) ? k - rise2 : k));
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL ext_req k=%0d got=%b exp=%b", k, got, exp);
         else pass_cnt++;
      end
      ext_req = 1'b0;
   endtask

   task automatic test_req_during_stretch();
      logic [4:0] got, exp;
      io_rst  = 1'b1;
      ext_req = 1'b0;
      repeat (3) tick();
      io_rst = 1'b0;
      for (int e = 1; e <= 45; e++) begin
         ext_req = (e == 18) || (e == 19);
         exp_q.push_back(exp_vec(e >= LOCK, e >= 30, e - 30));
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL req_in_stretch e=%0d got=%b exp=%b", e, got, exp);
         else pass_cnt++;
      end
      ext_req = 1'b0;
   endtask

   task automatic test_mid_reset();
      logic [4:0] got, exp;
      reset_release();
      for (int k = 1; k <= 12; k++) begin
         exp_q.push_back(exp_vec(1'b1, 1'b1, k));
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL mid_reset_pre k=%0d got=%b exp=%b", k, got, exp);
         else pass_cnt++;
      end
      io_rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back(rst_vec());
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL mid_reset_hold cyc=%0d got=%b exp=%b", i, got, exp);
         else pass_cnt++;
      end
      io_rst = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         exp_q.push_back(exp_vec(e >= LOCK, e >= LOCK + STRETCH, e - (LOCK + STRETCH)));
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL mid_reset_rerun e=%0d got=%b exp=%b", e, got, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_req_across_reset();
      logic [4:0] got, exp;
      io_rst  = 1'b1;
      ext_req = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back(rst_vec());
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL req_across_rst_hold cyc=%0d got=%b exp=%b", i, got, exp);
         else pass_cnt++;
      end
      io_rst = 1'b0;
      for (int e = 1; e <= 45; e++) begin
         ext_req = (e <= 20);
         exp_q.push_back(exp_vec(e >= LOCK, e >= 31, e - 31));
         tick();
         got = {locked, rst_n, clk_en, hb, clk_en1};
         exp = exp_q.pop_front();
         chk_cnt++;
         if (got !== exp) $display("FAIL req_across_rst e=%0d got=%b exp=%b", e, got, exp);
         else pass_cnt++;
      end
      ext_req = 1'b0;
   endtask

   initial begin
      io_rst  = 1'b1;
      ext_req = 1'b0;
      test_reset();
      test_power_up();
      test_heartbeat();
      test_ext_req();
      test_req_during_stretch();
      test_mid_reset();
      test_req_across_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
